fir_mac_filter: RTL and testbench
=================================

Name: fir_mac_filter

Overview:
- Time-multiplexed, single-multiplier, signed FIR filter stage.
- Sits directly downstream of the deserializer: consumes its parallel sample word over a valid/ready handshake.
- Produces one filtered word per accepted sample for the downstream serializer/sink.
- Uses one multiply-accumulate per cycle over TAPS cycles per sample, trading throughput for area.

Parameters:
- DATA_W, 24, input sample width (signed two's complement); must match the deserializer LENGTH.
- OUT_W, 24, output word width (signed).
- TAPS, 8, number of filter taps; must be 2 or more.
- COEF_W, 16, coefficient width (signed).
- SHIFT, 0, arithmetic right shift applied to the accumulator before output.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  stage enable; low stalls all state progress.
- iv_din  in  DATA_W  sample from the deserializer (its ov_dout).
- i_din_valid  in  1  sample valid (the deserializer's o_dout_valid).
- o_ready  out  1  filter can accept a sample; drives the deserializer's i_ready.
- ov_dout  out  OUT_W  filtered output word.
- o_dout_valid  out  1  ov_dout valid.
- i_ready  in  1  downstream can accept ov_dout.

Behaviour:
- Reset (i_rst=1 at an edge): delay line all zero, accumulator 0, tap index 0, state IDLE, ov_dout=0, o_dout_valid=0, o_ready=0. Reset overrides i_en and any in-flight operation, including reset mid-MAC or mid-OUT; the partial result is discarded.
- Delay line: TAPS entries x[0..TAPS-1], where x[0] is the newest sample.
- Coefficients: constant array C[0..TAPS-1] from the package.
- Output equation: y = sum over k of C[k]*x[k].
- State IDLE:
  - o_ready = i_en.
  - Accept on an edge where i_din_valid & o_ready & i_en.
  - On accept: shift the delay line (x[k] <= x[k-1], x[0] <= iv_din), clear acc, set k=0, go to MAC. o_ready drops the next cycle.
- State MAC:
  - One product per enabled cycle: acc += C[k]*x[k] (full-precision signed), k++.
  - After k=TAPS-1 is accumulated, go to OUT.
  - o_ready=0 throughout.
- State OUT:
  - ov_dout is registered on entry to OUT; o_dout_valid=1.
  - ov_dout and o_dout_valid stay stable while i_ready=0.
  - Handshake completes on an edge with i_ready=1 & i_en: o_dout_valid <= 0, return to IDLE.
  - ov_dout keeps its last value after the handshake.
- Latency: accept at edge 0, o_dout_valid high after edge TAPS+1 (TAPS MAC edges plus one output edge), assuming i_en stays high. Throughput is at most 1 sample per TAPS+2 cycles.
- i_en=0: state, k, acc and the delay line freeze; o_ready=0; o_dout_valid and ov_dout hold; i_ready is ignored.
- Widths:
  - ACC_W = DATA_W + COEF_W + clog2(TAPS).
  - Default output is acc >>> SHIFT truncated to the low OUT_W bits (wrap-around).
- Simultaneous i_din_valid during MAC/OUT: ignored (o_ready=0); upstream must hold its word.

Optional Feature:
- Macro: FIR_ROUND_SAT_EN.
- Defined:
  - Before shifting, add 1 << (SHIFT-1) when SHIFT > 0 (round half up).
  - Clamp the shifted value to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Adds one register stage: OUT entry happens one cycle later, so latency is TAPS+2.
- Undefined: truncate and wrap as above; latency TAPS+1.

Decomposition:
- Package fir_pkg:
  - DATA_W/COEF_W/TAPS defaults.
  - Coefficient array type and constant FIR_COEFS = {1,2,3,4,4,3,2,1}.
  - State enum {IDLE, MAC, OUT}.
  - ACC_W computation function.
- One sub-module fir_tap_line: TAPS-deep shift register with shift enable and an indexed read port selected by k.

Test Plan:
1. Impulse: 1 followed by 8 zeros, i_ready=1 -> outputs 1,2,3,4,4,3,2,1,0; first o_dout_valid exactly TAPS+1 cycles after accept (TAPS+2 with the macro).
2. Step: 9 samples of 100 -> outputs 100,300,600,1000,1400,1700,1900,2000,2000.
3. Negative impulse: -1 (0xFFFFFF) then zeros -> 0xFFFFFF,0xFFFFFE,0xFFFFFD,0xFFFFFC,0xFFFFFC,0xFFFFFD,0xFFFFFE,0xFFFFFF.
4. Overflow: 8 samples of 0x7FFFFF, then check the 8th output.
   - Without macro: expect 0xFFFFEC (wrap).
   - With FIR_ROUND_SAT_EN: expect 0x7FFFFF.
5. Backpressure/enable: hold i_ready=0 for 20 cycles in OUT -> ov_dout stable, o_ready=0, a second presented sample is not consumed.
   - Drop i_en for 5 cycles mid-MAC -> final result unchanged and latency extended by 5.
6. Reset mid-MAC: assert i_rst at k=3 -> next cycle all outputs 0, delay line cleared; a subsequent impulse reproduces scenario 1 exactly.

Source files
------------

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed FIR filter stage:
//   - default widths and tap count
//   - coefficient type and the constant coefficient set FIR_COEFS
//   - FSM state enum (IDLE, MAC, OUT)
//   - accumulator width helper and a bounds-safe coefficient lookup
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int COEF_W_DEF = 16;
  localparam int OUT_W_DEF  = 24;
  localparam int TAPS_DEF   = 8;

  typedef logic signed [COEF_W_DEF-1:0] coef_t;
  typedef coef_t coef_arr_t [TAPS_DEF];

  localparam coef_arr_t FIR_COEFS = '{
    16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd4, 16'sd3, 16'sd2, 16'sd1
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Full-precision accumulator width: product width plus growth for TAPS sums.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Indices past the stored set read as zero, so the MAC index may safely
  // run one step beyond the last tap while the output is being formed.
  function automatic coef_t coef_at(input int idx);
    if (idx >= 0 && idx < TAPS_DEF) return FIR_COEFS[idx];
    return '0;
  endfunction

endpackage

// File: rtl/fir_tap_line.sv
// ---------------------------------------------------------------------------
// fir_tap_line
// TAPS-deep sample delay line with a single indexed read port.
// x[0] is the newest sample; a shift moves every entry one place older.
// Ports:
//   i_clk    clock (rising edge)
//   i_rst    synchronous active-high reset, clears every entry
//   i_shift  push iv_din into x[0] and age the line by one
//   iv_din   new sample
//   iv_idx   tap index to read; out-of-range indices read zero
//   ov_tap   x[iv_idx]
// ---------------------------------------------------------------------------
module fir_tap_line #(
  parameter int DATA_W = 24,
  parameter int TAPS   = 8,
  parameter int IDX_W  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_shift,
  input  logic signed [DATA_W-1:0] iv_din,
  input  logic        [IDX_W-1:0]  iv_idx,
  output logic signed [DATA_W-1:0] ov_tap
);

  logic signed [DATA_W-1:0] x_q [TAPS];

  // Delay line storage: cleared by reset, aged by one on every shift.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (i_shift) begin
      x_q[0] <= iv_din;
      for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  // Read mux; the MAC index may point one past the end, which reads zero.
  always_comb begin
    ov_tap = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (iv_idx == IDX_W'(i)) ov_tap = x_q[i];
    end
  end

endmodule

// File: rtl/fir_mac_filter.sv
// ---------------------------------------------------------------------------
// fir_mac_filter
// Single-multiplier signed FIR stage. Each accepted sample is shifted into
// the delay line, then TAPS multiply-accumulate cycles form
// y = sum C[k]*x[k], followed by an output cycle that registers ov_dout.
// Build option: define FIR_ROUND_SAT_EN to round half up before the shift
// and saturate to OUT_W bits; this adds one register stage (latency
// TAPS+2 instead of TAPS+1). Without it the output is acc >>> SHIFT
// truncated (wrap-around).
// Ports:
//   i_clk         clock (rising edge)
//   i_rst         synchronous active-high reset
//   i_en          stage enable; low freezes all state
//   iv_din        input sample (signed)
//   i_din_valid   input sample valid
//   o_ready       filter can accept a sample
//   ov_dout       filtered output word (signed)
//   o_dout_valid  ov_dout valid
//   i_ready       downstream can accept ov_dout
// ---------------------------------------------------------------------------
module fir_mac_filter
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int SHIFT  = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] iv_din,
  input  logic                     i_din_valid,
  output logic                     o_ready,
  output logic signed [OUT_W-1:0]  ov_dout,
  output logic                     o_dout_valid,
  input  logic                     i_ready
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  // k runs 0..TAPS-1 for products, then TAPS (and TAPS+1) for output forming.
  localparam int KW    = $clog2(TAPS + 3);

  state_e                   state_q, state_d;
  logic        [KW-1:0]     k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  dout_q, dout_d;
  logic                     dvalid_q, dvalid_d;
  logic                     shift_en;

  logic signed [DATA_W-1:0] tap_rd;
  logic signed [ACC_W-1:0]  coef_ext;
  logic signed [ACC_W-1:0]  tap_ext;
  logic signed [ACC_W-1:0]  prod;

`ifdef FIR_ROUND_SAT_EN
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND_ADD =
    (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : '0;
  localparam logic signed [ACC_W:0] OUT_MAX =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] rs_q, rs_d;
  logic signed [OUT_W-1:0] sat_val;

  assign acc_ext = {acc_q[ACC_W-1], acc_q};

  // Clamp the rounded, shifted value into the signed OUT_W range.
  always_comb begin
    sat_val = rs_q[OUT_W-1:0];
    if (rs_q > OUT_MAX)      sat_val = OUT_MAX[OUT_W-1:0];
    else if (rs_q < OUT_MIN) sat_val = OUT_MIN[OUT_W-1:0];
  end
`endif

  fir_tap_line #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .IDX_W  (KW)
  ) u_tap_line (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_shift (shift_en),
    .iv_din  (iv_din),
    .iv_idx  (k_q),
    .ov_tap  (tap_rd)
  );

  // Size casts keep signedness, so both operands are sign-extended to ACC_W.
  assign coef_ext = ACC_W'(coef_at(int'(k_q)));
  assign tap_ext  = ACC_W'(tap_rd);
  assign prod     = coef_ext * tap_ext;

  // Reset also forces ready low so nothing is accepted during reset.
  assign o_ready      = (state_q == IDLE) && i_en && !i_rst;
  assign ov_dout      = dout_q;
  assign o_dout_valid = dvalid_q;

  // Next-state logic: everything holds unless enabled and the state acts.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    shift_en = 1'b0;
`ifdef FIR_ROUND_SAT_EN
    rs_d     = rs_q;
`endif
    if (i_en) begin
      case (state_q)
        IDLE: begin
          if (i_din_valid) begin
            shift_en = 1'b1;
            acc_d    = '0;
            k_d      = '0;
            state_d  = MAC;
          end
        end
        MAC: begin
          if (k_q < KW'(TAPS)) begin
            acc_d = acc_q + prod;
            k_d   = k_q + KW'(1);
          end
`ifdef FIR_ROUND_SAT_EN
          else if (k_q == KW'(TAPS)) begin
            rs_d = (acc_ext + RND_ADD) >>> SHIFT;
            k_d  = k_q + KW'(1);
          end else begin
            dout_d   = sat_val;
            dvalid_d = 1'b1;
            state_d  = OUT;
          end
`else
          else begin
            dout_d   = OUT_W'(acc_q >>> SHIFT);
            dvalid_d = 1'b1;
            state_d  = OUT;
          end
`endif
        end
        OUT: begin
          if (i_ready) begin
            dvalid_d = 1'b0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset that discards any partial result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
`ifdef FIR_ROUND_SAT_EN
      rs_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
`ifdef FIR_ROUND_SAT_EN
      rs_q     <= rs_d;
`endif
    end
  end

endmodule

// File: tb/tb_fir_mac_filter.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_filter
// Self-checking bench for fir_mac_filter. A plain-arithmetic model keeps the
// sample history and computes sum C[k]*x[k] with the output rule of the
// selected build (FIR_ROUND_SAT_EN rounds/saturates, otherwise wraps).
// ---------------------------------------------------------------------------
module tb_fir_mac_filter;

  localparam int TAPS  = 8;
  localparam int OUT_W = 24;
  localparam int SHIFT = 0;
`ifdef FIR_ROUND_SAT_EN
  localparam int LAT = TAPS + 2;
  localparam logic [23:0] OVF_EXP = 24'h7FFFFF;
`else
  localparam int LAT = TAPS + 1;
  localparam logic [23:0] OVF_EXP = 24'hFFFFEC;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic [23:0] iv_din;
  logic        i_din_valid;
  logic        o_ready;
  logic [23:0] ov_dout;
  logic        o_dout_valid;
  logic        i_ready;

  int total = 0;
  int bad   = 0;

  longint hist [TAPS];
  int     coef [TAPS] = '{1, 2, 3, 4, 4, 3, 2, 1};

  fir_mac_filter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .iv_din       (iv_din),
    .i_din_valid  (i_din_valid),
    .o_ready      (o_ready),
    .ov_dout      (ov_dout),
    .o_dout_valid (o_dout_valid),
    .i_ready      (i_ready)
  );

  always #5 i_clk = ~i_clk;

  // Reference: push a sample into the history and return the expected word.
  function automatic logic [23:0] model_push(input logic [23:0] s);
    longint acc;
    longint hi;
    longint lo;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = longint'($signed(s));
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(coef[k]) * hist[k];
`ifdef FIR_ROUND_SAT_EN
    acc += (longint'(1) << SHIFT) >> 1;
    acc = acc >>> SHIFT;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
`else
    hi = 0;
    lo = 0;
    acc = acc >>> SHIFT;
`endif
    return acc[23:0];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
  endtask

  // Send one sample, optionally dropping i_en for stall_len edges starting
  // stall_at edges after the accept, and return the output and its latency.
  task automatic run_sample(input logic [23:0] s, input int stall_at,
                            input int stall_len, output logic [23:0] y,
                            output int lat);
    int guard;
    y   = '0;
    lat = -1;
    @(negedge i_clk);
    guard = 0;
    while (!o_ready && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_wait: o_ready=%b required 1", o_ready);
      return;
    end
    iv_din      = s;
    i_din_valid = 1'b1;
    @(posedge i_clk);
    #1 i_din_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge i_clk);
      lat++;
      #1;
      if (stall_len > 0 && lat == stall_at) i_en = 1'b0;
      if (stall_len > 0 && lat == stall_at + stall_len) i_en = 1'b1;
      if (o_dout_valid) break;
    end
    if (!o_dout_valid) begin
      total++;
      bad++;
      i_en = 1'b1;
      $display("[TB] FAIL valid_wait: o_dout_valid=%b required 1", o_dout_valid);
      return;
    end
    y = ov_dout;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst       = 1'b1;
    i_en        = 1'b1;
    i_ready     = 1'b1;
    i_din_valid = 1'b0;
    iv_din      = '0;
    clear_model();
    repeat (3) @(posedge i_clk);
    #1;
    total++;
    if (ov_dout !== 24'h0) begin
      bad++;
      $display("[TB] FAIL reset_dout: got %h required 000000", ov_dout);
    end
    total++;
    if (o_dout_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_valid: got %b required 0", o_dout_valid);
    end
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b required 0", o_ready);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_ready: got %b required 1", o_ready);
    end
  endtask

  task automatic test_impulse(input string tag);
    logic [23:0] exp_tab [9] = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd4,
                                 24'd3, 24'd2, 24'd1, 24'd0};
    logic [23:0] y;
    logic [23:0] m;
    int lat;
    for (int i = 0; i < 9; i++) begin
      m = model_push((i == 0) ? 24'd1 : 24'd0);
      run_sample((i == 0) ? 24'd1 : 24'd0, 0, 0, y, lat);
      total++;
      if (y !== exp_tab[i]) begin
        bad++;
        $display("[TB] FAIL %s_out%0d: got %h required %h", tag, i, y, exp_tab[i]);
      end
      if (i == 0) begin
        total++;
        if (lat != LAT) begin
          bad++;
          $display("[TB] FAIL %s_latency: got %0d required %0d", tag, lat, LAT);
        end
      end
    end
  endtask

  task automatic test_step();
    logic [23:0] exp_tab [9] = '{24'd100, 24'd300, 24'd600, 24'd1000, 24'd1400,
                                 24'd1700, 24'd1900, 24'd2000, 24'd2000};
    logic [23:0] y;
    logic [23:0] m;
    int lat;
    for (int i = 0; i < 9; i++) begin
      m = model_push(24'd100);
      run_sample(24'd100, 0, 0, y, lat);
      total++;
      if (y !== exp_tab[i]) begin
        bad++;
        $display("[TB] FAIL step_out%0d: got %h required %h", i, y, exp_tab[i]);
      end
    end
  endtask

  task automatic test_negative();
    logic [23:0] exp_tab [8] = '{24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC,
                                 24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF};
    logic [23:0] y;
    logic [23:0] m;
    int lat;
    for (int i = 0; i < TAPS; i++) begin
      m = model_push(24'd0);
      run_sample(24'd0, 0, 0, y, lat);
    end
    for (int i = 0; i < 8; i++) begin
      m = model_push((i == 0) ? 24'hFFFFFF : 24'd0);
      run_sample((i == 0) ? 24'hFFFFFF : 24'd0, 0, 0, y, lat);
      total++;
      if (y !== exp_tab[i]) begin
        bad++;
        $display("[TB] FAIL neg_out%0d: got %h required %h", i, y, exp_tab[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] y;
    logic [23:0] m;
    int lat;
    for (int i = 0; i < TAPS; i++) begin
      m = model_push(24'h7FFFFF);
      run_sample(24'h7FFFFF, 0, 0, y, lat);
    end
    total++;
    if (y !== OVF_EXP) begin
      bad++;
      $display("[TB] FAIL overflow_out: got %h required %h", y, OVF_EXP);
    end
  endtask

  task automatic test_random();
    logic [23:0] s;
    logic [23:0] y;
    logic [23:0] m;
    int lat;
    for (int i = 0; i < 16; i++) begin
      s = 24'($urandom);
      m = model_push(s);
      run_sample(s, 0, 0, y, lat);
      total++;
      if (y !== m) begin
        bad++;
        $display("[TB] FAIL random_out%0d: in %h got %h required %h", i, s, y, m);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [23:0] s1;
    logic [23:0] s2;
    logic [23:0] m;
    logic [23:0] y;
    int guard;
    int lat;
    s1 = 24'($urandom) | 24'h000010;
    s2 = 24'($urandom) | 24'h000100;
    m  = model_push(s1);
    i_ready = 1'b0;
    @(negedge i_clk);
    guard = 0;
    while (!o_ready && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    iv_din      = s1;
    i_din_valid = 1'b1;
    @(posedge i_clk);
    #1 i_din_valid = 1'b0;
    guard = 0;
    while (!o_dout_valid && guard < 100) begin
      @(posedge i_clk);
      #1;
      guard++;
    end
    total++;
    if (ov_dout !== m || o_dout_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_first: got %h valid %b required %h valid 1",
               ov_dout, o_dout_valid, m);
    end
    iv_din      = s2;
    i_din_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk);
      #1;
      total++;
      if (ov_dout !== m || o_dout_valid !== 1'b1 || o_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d: dout %h valid %b ready %b required %h 1 0",
                 c, ov_dout, o_dout_valid, o_ready, m);
      end
    end
    i_din_valid = 1'b0;
    i_ready     = 1'b1;
    @(posedge i_clk);
    #1;
    total++;
    if (o_dout_valid !== 1'b0 || ov_dout !== m) begin
      bad++;
      $display("[TB] FAIL bp_release: valid %b dout %h required 0 %h",
               o_dout_valid, ov_dout, m);
    end
    m = model_push(s2);
    run_sample(s2, 0, 0, y, lat);
    total++;
    if (y !== m) begin
      bad++;
      $display("[TB] FAIL bp_second: got %h required %h", y, m);
    end
  endtask

  task automatic test_enable();
    logic [23:0] s;
    logic [23:0] y;
    logic [23:0] m;
    int lat;
    s = 24'($urandom);
    m = model_push(s);
    run_sample(s, 3, 5, y, lat);
    total++;
    if (y !== m) begin
      bad++;
      $display("[TB] FAIL enable_out: got %h required %h", y, m);
    end
    total++;
    if (lat != LAT + 5) begin
      bad++;
      $display("[TB] FAIL enable_latency: got %0d required %0d", lat, LAT + 5);
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [23:0] s;
    logic [23:0] m;
    int guard;
    s = 24'($urandom) | 24'h000001;
    m = model_push(s);
    @(negedge i_clk);
    guard = 0;
    while (!o_ready && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    iv_din      = s;
    i_din_valid = 1'b1;
    @(posedge i_clk);
    #1 i_din_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    total++;
    if (ov_dout !== 24'h0 || o_dout_valid !== 1'b0 || o_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midmac_reset: dout %h valid %b ready %b required 000000 0 0",
               ov_dout, o_dout_valid, o_ready);
    end
    i_rst = 1'b0;
    clear_model();
    test_impulse("post_reset");
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_step();
    test_negative();
    test_overflow();
    test_random();
    test_back_to_back_stall();
    test_enable();
    test_reset_mid_mac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
